// File: rtl/hazard_scoreboard.sv
// Operand-hazard scoreboard: tracks in-flight destinations, picks the youngest forwardable
// producer per source operand, and stalls ID while a matching load's data is not yet valid.
module hazard_scoreboard #(
    parameter int XLEN       = 32,
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    input  logic                    issue_wr,
    input  logic [REG_AW-1:0]       issue_rd,
    input  logic                    issue_load,
    input  logic                    issue_kill,
    input  logic [REG_AW-1:0]       src1_sel,
    input  logic                    src1_used,
    input  logic [REG_AW-1:0]       src2_sel,
    input  logic                    src2_used,
    input  logic [DEPTH*XLEN-1:0]   stage_data,
    output logic                    fwd1_hit,
    output logic [XLEN-1:0]         fwd1_data,
    output logic                    fwd2_hit,
    output logic [XLEN-1:0]         fwd2_data,
    output logic                    stall,
    output logic [3:0]              inflight,
    output logic [15:0]             stall_cnt
);

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic [REG_AW-1:0] rd;
        logic              load;
    } slot_t;

    typedef struct packed {
        logic            found;
        logic            blocked;
        logic [XLEN-1:0] data;
    } fwd_t;

    slot_t       slots_q [DEPTH];
    slot_t       slots_d [DEPTH];
    logic [3:0]  inflight_q, inflight_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    fwd_t        fwd1, fwd2;

    // Scans oldest to youngest so the lowest matching slot index is the one left standing.
    function automatic fwd_t youngest(input slot_t s [DEPTH], input logic [REG_AW-1:0] sel,
                                      input logic used, input logic [DEPTH*XLEN-1:0] data);
        fwd_t r;
        r = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (used && sel != '0 && s[k].valid && s[k].wr && s[k].rd == sel) begin
                r.found   = 1'b1;
                r.blocked = s[k].load && (k < LOAD_READY);
                r.data    = data[k*XLEN +: XLEN];
            end
        end
        return r;
    endfunction

    always_comb begin
        fwd1      = youngest(slots_q, src1_sel, src1_used, stage_data);
        fwd2      = youngest(slots_q, src2_sel, src2_used, stage_data);
        stall     = fwd1.blocked | fwd2.blocked;
        fwd1_hit  = fwd1.found & ~fwd1.blocked;
        fwd2_hit  = fwd2.found & ~fwd2.blocked;
        fwd1_data = fwd1_hit ? fwd1.data : '0;
        fwd2_data = fwd2_hit ? fwd2.data : '0;
    end

    always_comb begin
        // NOTE: every next-state variable gets a default first so no path can infer a latch.
        slots_d[0]  = '0;
        inflight_d  = '0;
        stall_cnt_d = stall_cnt_q;
        if (issue_valid && !issue_kill && !stall) begin
            slots_d[0] = '{valid: 1'b1, wr: issue_wr, rd: issue_rd, load: issue_load};
        end
        for (int k = 1; k < DEPTH; k++) begin
            slots_d[k] = slots_q[k-1];
        end
        for (int k = 0; k < DEPTH; k++) begin
            inflight_d = inflight_d + 4'(slots_d[k].valid);
        end
        if (stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State moves on the falling edge, together with the pipeline registers it shadows.
    always_ff @(negedge clk) begin
        if (rst) begin
            // NOTE: the slot array must be reset; a stale valid bit would forward garbage after reset.
            for (int k = 0; k < DEPTH; k++) begin
                slots_q[k] <= '0;
            end
            inflight_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            slots_q     <= slots_d;
            inflight_q  <= inflight_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign inflight  = inflight_q;
    assign stall_cnt = stall_cnt_q;

endmodule
